// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by the front-end blocks.
package riscv_pkg;

    parameter int XLEN = 32;

    // Canonical NOP: addi x0, x0, 0
    parameter logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory port of the fetch unit.
//
// Handshake rules:
//   Request : a request transfers on a rising edge where imem_req_valid and
//             imem_req_ready are both high. While valid is high and ready is
//             low, the requester holds imem_addr stable. Valid never waits
//             on ready.
//   Response: imem_rsp_valid is a single-cycle pulse carrying imem_rsp_data.
//             There is no response back-pressure. Exactly one response follows
//             each accepted request, and at most one request is outstanding.
interface if_fetch_unit_if #(
    parameter int XLEN = 32
) ();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    // Fetch-unit side
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one request per PC, buffers the returned
// word for IF/ID and advances or redirects the PC. A redirect that lands while
// a response is still in flight turns that response into a discard (S_DROP),
// so a stale word can never be presented for the new PC.
module if_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    if_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]  PCF,
    output logic [XLEN-1:0]  PCPlus4F,
    output logic [31:0]      InstrF,
    output logic             InstrValidF,
    output logic [1:0]       fetch_state_o
);

    import riscv_pkg::INSTR_NOP;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request for PCF presented to memory
        S_WAIT = 2'd1,  // request accepted, waiting for its response
        S_HOLD = 2'd2,  // instruction buffered and offered to IF/ID
        S_DROP = 2'd3   // redirected while in flight: swallow the response
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_buf_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] target_aligned;

    // Sequential PC and redirect target; both keep bits [1:0] at zero
    always_comb begin
        pc_plus4       = pc_q + XLEN'(4);
        target_aligned = PCTargetE & ~XLEN'(3);
    end

    // Fetch FSM: state, PC and instruction buffer; redirect outranks stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC & ~XLEN'(3);
            instr_buf_q <= INSTR_NOP;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (PCSrcE) begin
                        // Request is suppressed this cycle; reissue at target
                        pc_q <= target_aligned;
                    end else if (imem.imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (PCSrcE) begin
                        pc_q    <= target_aligned;
                        // Response arriving with the redirect is simply ignored
                        state_q <= imem.imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem.imem_rsp_valid) begin
                        instr_buf_q <= imem.imem_rsp_data;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (PCSrcE) begin
                        pc_q        <= target_aligned;
                        instr_buf_q <= INSTR_NOP;
                        state_q     <= S_REQ;
                    end else if (!StallF) begin
                        // IF/ID takes the instruction on this edge
                        pc_q        <= pc_plus4;
                        instr_buf_q <= INSTR_NOP;
                        state_q     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (PCSrcE) begin
                        pc_q <= target_aligned;
                    end
                    if (imem.imem_rsp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    // Memory request: only the redirect path is combinational
    always_comb begin
        imem.imem_req_valid = (state_q == S_REQ) && !PCSrcE;
        imem.imem_addr      = pc_q;
    end

    // IF/ID-facing outputs, all derived from registered state
    always_comb begin
        PCF           = pc_q;
        PCPlus4F      = pc_plus4;
        InstrValidF   = (state_q == S_HOLD);
        InstrF        = (state_q == S_HOLD) ? instr_buf_q : INSTR_NOP;
        fetch_state_o = state_q;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a directed prologue covering reset, cadence,
// stall, redirect-drop, back-pressure, PC wrap and reset-in-hold, then a
// randomized run. A transaction-level model tracks the architectural PC, the
// outstanding memory request and whether an instruction for the PC is in hand.
module tb_if_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            stall_f;
    logic            pcsrc_e;
    logic [XLEN-1:0] pc_target_e;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pc_plus4_f;
    logic [31:0]     instr_f;
    logic            instr_valid_f;
    logic [1:0]      fetch_state;

    if_fetch_unit_if #(.XLEN(XLEN)) imem ();

    if_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .StallF        (stall_f),
        .PCSrcE        (pcsrc_e),
        .PCTargetE     (pc_target_e),
        .imem          (imem),
        .PCF           (pcf),
        .PCPlus4F      (pc_plus4_f),
        .InstrF        (instr_f),
        .InstrValidF   (instr_valid_f),
        .fetch_state_o (fetch_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0050_0093;
        return {addr[15:0], ~addr[31:16]} ^ 32'h5a5a_3c3c;
    endfunction

    // ---------------- stimulus knobs ----------------
    logic        k_rst;
    logic        k_stall;
    logic        k_redir;
    logic [31:0] k_tgt;
    logic        k_ready;
    int          k_lat;     // response arrives k_lat cycles after accept

    // ---------------- reference model ----------------
    logic [31:0] exp_pc;     // architectural fetch PC
    logic        pending;    // a request is outstanding at the memory
    logic        stale;      // the outstanding request belongs to an old PC
    logic [31:0] pend_addr;
    int          rsp_cnt;
    logic        got_rsp;    // a word for exp_pc has returned and is not yet consumed
    int          consumed;

    // One clock: apply knobs at the negedge, advance the model across the
    // rising edge, then compare at the following negedge.
    task automatic step();
        logic deliver;
        logic had;
        rst                 = k_rst;
        stall_f             = k_stall;
        pcsrc_e             = k_redir;
        pc_target_e         = k_tgt;
        imem.imem_req_ready = k_ready;
        deliver             = pending && (rsp_cnt == 1) && !k_rst;
        imem.imem_rsp_valid = deliver;
        imem.imem_rsp_data  = deliver ? mem_word(pend_addr) : $urandom();
        #1;
        had = got_rsp;
        if (k_rst) begin
            exp_pc  = RESET_PC;
            pending = 1'b0;
            stale   = 1'b0;
            got_rsp = 1'b0;
        end else begin
            if (deliver) begin
                pending = 1'b0;
                if (!stale && !k_redir) got_rsp = 1'b1;
                stale = 1'b0;
            end else if (pending) begin
                rsp_cnt--;
            end
            if (imem.imem_req_valid && k_ready) begin
                check_eq("req_outstanding", {31'd0, pending}, 32'd0);
                check_eq("req_addr", imem.imem_addr, exp_pc);
                pending   = 1'b1;
                stale     = 1'b0;
                pend_addr = imem.imem_addr;
                rsp_cnt   = k_lat;
            end
            if (k_redir) begin
                exp_pc  = k_tgt & ~32'd3;
                got_rsp = 1'b0;
                if (pending) stale = 1'b1;
            end else if (had && !k_stall) begin
                exp_pc  = exp_pc + 32'd4;
                got_rsp = 1'b0;
                consumed++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("pcf", pcf, exp_pc);
        check_eq("imem_addr", imem.imem_addr, exp_pc);
        check_eq("pc_plus4", pc_plus4_f, exp_pc + 32'd4);
        check_eq("instr_valid", {31'd0, instr_valid_f}, {31'd0, got_rsp});
        check_eq("instr", instr_f, got_rsp ? mem_word(exp_pc) : NOP);
        // Nothing held and nothing in flight means the unit must be asking
        check_eq("req_valid", {31'd0, imem.imem_req_valid},
                 {31'd0, !pending && !got_rsp && !pcsrc_e});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; stall_f = 1'b0; pcsrc_e = 1'b0; pc_target_e = '0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
        k_rst = 1'b1; k_stall = 1'b0; k_redir = 1'b0; k_tgt = '0; k_ready = 1'b1; k_lat = 1;
        exp_pc = RESET_PC; pending = 1'b0; stale = 1'b0; pend_addr = '0; rsp_cnt = 0;
        got_rsp = 1'b0; consumed = 0;

        @(negedge clk);
        step();
        check_eq("rst_pcf", pcf, 32'h0);
        check_eq("rst_addr", imem.imem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, instr_valid_f}, 32'd0);
        check_eq("rst_instr", instr_f, NOP);

        // Zero-wait cadence from reset
        k_rst = 1'b0;
        step();
        step();
        check_eq("first_valid", {31'd0, instr_valid_f}, 32'd1);
        check_eq("first_instr", instr_f, 32'h0050_0093);
        step();
        check_eq("first_next_pc", pcf, 32'h4);
        check_eq("first_consumed", {31'd0, instr_valid_f}, 32'd0);

        // Stall held in hold state
        step();
        step();
        check_eq("hold_valid", {31'd0, instr_valid_f}, 32'd1);
        k_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall_pcf", pcf, 32'h4);
            check_eq("stall_instr", instr_f, mem_word(32'h4));
            check_eq("stall_valid", {31'd0, instr_valid_f}, 32'd1);
            check_eq("stall_no_req", {31'd0, imem.imem_req_valid}, 32'd0);
        end
        k_stall = 1'b0;
        step();
        check_eq("stall_release_pc", pcf, 32'h8);

        // Redirect while waiting; response arrives two cycles later
        k_lat = 3;
        step();
        k_redir = 1'b1; k_tgt = 32'h0000_0103;
        step();
        check_eq("redir_pcf", pcf, 32'h100);
        k_redir = 1'b0;
        step();
        check_eq("drop_valid_a", {31'd0, instr_valid_f}, 32'd0);
        step();
        check_eq("drop_valid_b", {31'd0, instr_valid_f}, 32'd0);
        check_eq("drop_next_req", {31'd0, imem.imem_req_valid}, 32'd1);
        check_eq("drop_next_addr", imem.imem_addr, 32'h100);

        // Memory back-pressure
        k_lat = 1; k_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
            check_eq("bp_addr", imem.imem_addr, 32'h100);
        end
        k_ready = 1'b1;
        step();
        check_eq("bp_accepted", {31'd0, imem.imem_req_valid}, 32'd0);
        step();
        check_eq("bp_instr", instr_f, mem_word(32'h100));

        // PC wrap at the top of the address space
        k_redir = 1'b1; k_tgt = 32'hFFFF_FFFC;
        step();
        k_redir = 1'b0;
        step();
        step();
        check_eq("wrap_valid", {31'd0, instr_valid_f}, 32'd1);
        check_eq("wrap_plus4", pc_plus4_f, 32'h0);
        step();
        check_eq("wrap_pcf", pcf, 32'h0);

        // Reset while holding a stalled instruction
        step();
        step();
        k_stall = 1'b1;
        step();
        check_eq("pre_rst_valid", {31'd0, instr_valid_f}, 32'd1);
        k_rst = 1'b1;
        step();
        check_eq("rst_hold_pcf", pcf, RESET_PC);
        check_eq("rst_hold_valid", {31'd0, instr_valid_f}, 32'd0);
        check_eq("rst_hold_instr", instr_f, NOP);
        k_rst = 1'b0; k_stall = 1'b0;

        // Randomized run
        for (int i = 0; i < 1500; i++) begin
            k_rst   = ($urandom_range(0, 99) == 0);
            k_stall = ($urandom_range(0, 2) == 0);
            k_redir = ($urandom_range(0, 14) == 0);
            k_tgt   = $urandom();
            k_ready = ($urandom_range(0, 3) != 0);
            k_lat   = $urandom_range(1, 3);
            step();
        end
        check_eq("progress", {31'd0, consumed == 0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter XLEN, default riscv_pkg::XLEN (32): PC/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC after reset.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 StallF  input  1  hazard unit holds fetch; the IF/ID register is not accepting.
REQ-006 PCSrcE  input  1  branch/jump redirect taken in Execute.
REQ-007 PCTargetE  input  XLEN  redirect target address.
REQ-008 imem_req_valid  output  1  instruction-memory request valid.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_addr  output  XLEN  request address; always equals PCF.
REQ-011 imem_rsp_valid  input  1  response data valid; one response per accepted request; at most one outstanding request.
REQ-012 imem_rsp_data  input  32  response instruction word.
REQ-013 PCF  output  XLEN  PC of the instruction presented to IF/ID.
REQ-014 PCPlus4F  output  XLEN  PCF + 4.
REQ-015 InstrF  output  32  instruction presented to IF/ID.
REQ-016 InstrValidF  output  1  InstrF holds a real fetched instruction for PCF.

Function
REQ-017 States: S_REQ, S_WAIT, S_HOLD, S_DROP; state and PCF are registered; all outputs are derived from registered state only, except imem_req_valid.
REQ-018 PCF[1:0] is always 2'b00; PCTargetE[1:0] is ignored.
REQ-019 PCPlus4F = PCF + 4, combinational, wraps modulo 2^XLEN (PCF=32'hFFFF_FFFC gives 0).
REQ-020 imem_req_valid = (state==S_REQ) & ~PCSrcE; imem_addr = PCF in every state.
REQ-021 S_REQ: on imem_req_valid & imem_req_ready -> S_WAIT; otherwise remain, holding the request stable.
REQ-022 S_WAIT: on imem_rsp_valid -> capture imem_rsp_data into the instruction buffer and move to S_HOLD.
REQ-023 S_HOLD: InstrValidF=1 and InstrF=buffer; if ~StallF then PCF <= PCPlus4F and state -> S_REQ (instruction consumed); if StallF, hold everything.
REQ-024 In all states other than S_HOLD: InstrValidF=0 and InstrF=INSTR_NOP (32'h0000_0013).
REQ-025 Redirect (PCSrcE=1), in any state, sets PCF <= PCTargetE; it has priority over StallF and over consumption.
REQ-026 Redirect in S_REQ: no request issues that cycle; stay in S_REQ.
REQ-027 Redirect in S_HOLD: discard the buffer and go to S_REQ.
REQ-028 Redirect in S_WAIT without imem_rsp_valid goes to S_DROP; with imem_rsp_valid the same cycle, discard the response and go to S_REQ.
REQ-029 S_DROP: InstrValidF=0; on imem_rsp_valid, discard the response and go to S_REQ. A further redirect in S_DROP only updates PCF.
REQ-030 A response never updates the buffer outside S_WAIT.
REQ-031 Minimum fetch cadence with zero-wait memory: one instruction every 3 cycles (REQ, WAIT, HOLD).

Reset
REQ-032 rst=1 at a clock edge forces: state=S_REQ, PCF=RESET_PC, buffer=INSTR_NOP, and InstrValidF=0 from the next cycle. An in-flight response is abandoned; the memory is reset together with this block.
REQ-033 rst has priority over PCSrcE, StallF and all memory handshakes.

Verification
REQ-034 Reset, then ready=1 and the response one cycle after accept, data=32'h00500093: PCF=0, imem_addr=0; InstrValidF=1 with InstrF=32'h00500093 on the third cycle after reset release; PCF=4 on the next cycle.
REQ-035 StallF=1 held for 4 cycles during S_HOLD: PCF, InstrF and InstrValidF stay constant; no new request; advance on the first cycle with StallF=0.
REQ-036 PCSrcE=1 with PCTargetE=32'h0000_0103 while in S_WAIT, response 2 cycles later: response dropped, InstrValidF stays 0, the next imem_addr is 32'h0000_0100.
REQ-037 imem_req_ready=0 for 3 cycles: imem_req_valid stays 1 and imem_addr stays constant; the request is accepted on the cycle ready rises.
REQ-038 PCF=32'hFFFF_FFFC, instruction consumed: PCPlus4F=0 and PCF becomes 0.
REQ-039 rst asserted while in S_HOLD with StallF=1: the next cycle has PCF=RESET_PC, InstrValidF=0 and InstrF=32'h0000_0013.
